fetch_bpu: RTL and testbench

//  Parametrised instruction-fetch stage with a configurable branch predictor (bimodal or gshare),

---
 rtl/fetch_bpu_pkg.sv | 27 ++
 rtl/fetch_bpu_if.sv | 40 ++++
 rtl/fetch_bpu_bht.sv | 59 +++++
 rtl/fetch_bpu.sv | 155 +++++++++++++++
 tb/tb_fetch_bpu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_bpu_pkg.sv
// Shared constants and helpers for the fetch/branch-prediction slice.
package fetch_bpu_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned PC_STEP    = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Weakly-taken counter value for a given counter width
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_bpu_if.sv
// Fetch-stage bus: ICache request/response, InstQueue push, ROB commit feedback.
interface fetch_bpu_if
  import fetch_bpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BHT_IDX_W = 8
);
  logic                 rdy;
  logic                 inst_valid;
  logic [INST_W-1:0]    inst;
  logic                 inst_en;
  logic [ADDR_W-1:0]    inst_addr;
  logic                 iq_full;
  logic                 iq_en;
  logic [INST_W-1:0]    iq_inst;
  logic [ADDR_W-1:0]    iq_pc;
  logic                 iq_bp;
  logic [BHT_IDX_W-1:0] iq_idx;
  logic                 commit_en;
  logic                 commit_isjalr;
  logic                 commit_judge;
  logic                 commit_bp;
  logic [BHT_IDX_W-1:0] commit_idx;
  logic [ADDR_W-1:0]    commit_pc;
  logic [ADDR_W-1:0]    commit_oripc;

  modport master (
    input  rdy, inst_valid, inst, iq_full,
           commit_en, commit_isjalr, commit_judge, commit_bp,
           commit_idx, commit_pc, commit_oripc,
    output inst_en, inst_addr, iq_en, iq_inst, iq_pc, iq_bp, iq_idx
  );

  modport slave (
    output rdy, inst_valid, inst, iq_full,
           commit_en, commit_isjalr, commit_judge, commit_bp,
           commit_idx, commit_pc, commit_oripc,
    input  inst_en, inst_addr, iq_en, iq_inst, iq_pc, iq_bp, iq_idx
  );
endinterface

// File: rtl/fetch_bpu_bht.sv
// Branch history table: saturating counters, bimodal or gshare index hash,
// non-speculative global history trained at commit.
module fetch_bpu_bht
  import fetch_bpu_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HIST_W    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [BHT_IDX_W-1:0] pc_idx,
  output logic [BHT_IDX_W-1:0] idx_c,
  output logic                 taken_c,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int unsigned      BHT_N    = 1 << BHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] ctr [BHT_N];
  logic [CTR_W-1:0] upd_cur;

  assign upd_cur = ctr[upd_idx];

  // Saturating train; the fetch-side read is combinational, so it sees the pre-update value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) ctr[i] <= CTR_INIT;
    end else if (rdy && upd_en) begin
      if (upd_taken) begin
        if (upd_cur != CTR_MAX) ctr[upd_idx] <= upd_cur + 1'b1;
      end else begin
        if (upd_cur != '0) ctr[upd_idx] <= upd_cur - 1'b1;
      end
    end
  end

  if (HIST_W > 0) begin : g_gshare
    logic [HIST_W-1:0] ghr;

    always_ff @(posedge clk) begin
      if (rst)                  ghr <= '0;
      else if (rdy && upd_en)   ghr <= HIST_W'({ghr, upd_taken});
    end

    // History occupies the top HIST_W bits of the index
    assign idx_c = pc_idx ^ (BHT_IDX_W'(ghr) << (BHT_IDX_W - HIST_W));
  end else begin : g_bimodal
    assign idx_c = pc_idx;
  end

  assign taken_c = ctr[idx_c][CTR_W-1];

endmodule

// File: rtl/fetch_bpu.sv
// Instruction fetch stage with branch prediction and commit-driven redirect.
// Optional JALR target prediction via a direct-mapped BTB when FETCH_BTB_EN is defined.
module fetch_bpu
  import fetch_bpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BHT_IDX_W = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HIST_W    = 0,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  fetch_bpu_if.master bus
);

  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    next_pc_c;
  logic [ADDR_W-1:0]    sum_c;
  logic                 pred_c;
  logic [6:0]           opc_c;
  logic [BHT_IDX_W-1:0] bht_idx_c;
  logic                 bht_taken_c;
  logic                 btb_hit_c;
  logic [ADDR_W-1:0]    btb_tgt_c;
  logic                 redirect_jalr_c;
  logic                 redirect_c;
  logic                 accept_c;

  assign opc_c = bus.inst[6:0];

  fetch_bpu_bht #(
    .BHT_IDX_W (BHT_IDX_W),
    .CTR_W     (CTR_W),
    .HIST_W    (HIST_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rdy       (bus.rdy),
    .pc_idx    (pc[BHT_IDX_W+1:2]),
    .idx_c     (bht_idx_c),
    .taken_c   (bht_taken_c),
    .upd_en    (bus.commit_en && !bus.commit_isjalr),
    .upd_idx   (bus.commit_idx),
    .upd_taken (bus.commit_judge)
  );

`ifdef FETCH_BTB_EN
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = ADDR_W - BTB_IDX_W - 2;

  logic                 btb_valid [BTB_N];
  logic [TAG_W-1:0]     btb_tag   [BTB_N];
  logic [ADDR_W-1:0]    btb_tgt   [BTB_N];
  logic [BTB_IDX_W-1:0] btb_rd_idx;
  logic [BTB_IDX_W-1:0] btb_wr_idx;
  logic                 btb_wr_c;
  logic                 unused_btb;

  assign btb_rd_idx      = pc[BTB_IDX_W+1:2];
  assign btb_wr_idx      = bus.commit_oripc[BTB_IDX_W+1:2];
  assign btb_wr_c        = bus.rdy && bus.commit_en && bus.commit_isjalr;
  assign btb_hit_c       = btb_valid[btb_rd_idx] &&
                           (btb_tag[btb_rd_idx] == pc[ADDR_W-1:BTB_IDX_W+2]);
  assign btb_tgt_c       = btb_tgt[btb_rd_idx];
  assign redirect_jalr_c = !(bus.commit_bp && bus.commit_judge);
  assign unused_btb      = ^bus.commit_oripc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (btb_wr_c) begin
      btb_valid[btb_wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (!rst && btb_wr_c) begin
      btb_tag[btb_wr_idx] <= bus.commit_oripc[ADDR_W-1:BTB_IDX_W+2];
      btb_tgt[btb_wr_idx] <= bus.commit_pc;
    end
  end
`else
  logic unused_btb;

  assign btb_hit_c       = 1'b0;
  assign btb_tgt_c       = '0;
  assign redirect_jalr_c = 1'b1;
  assign unused_btb      = ^{bus.commit_oripc, (BTB_IDX_W > 32'd0)};
`endif

  assign redirect_c = bus.commit_en &&
                      (bus.commit_isjalr ? redirect_jalr_c
                                         : (bus.commit_judge != bus.commit_bp));
  assign accept_c   = bus.inst_valid && !bus.iq_full;

  // Next-PC selection for the instruction arriving this cycle
  always_comb begin
    next_pc_c = pc + ADDR_W'(PC_STEP);
    sum_c     = '0;
    pred_c    = 1'b0;
    case (opc_c)
      OPC_JAL: begin
        sum_c     = pc + ADDR_W'($signed(imm_j(bus.inst)));
        next_pc_c = {sum_c[ADDR_W-1:2], pc[1:0]};
      end
      OPC_BRANCH: begin
        pred_c = bht_taken_c;
        if (bht_taken_c) begin
          sum_c     = pc + ADDR_W'($signed(imm_b(bus.inst)));
          next_pc_c = {sum_c[ADDR_W-1:2], pc[1:0]};
        end
      end
      OPC_JALR: begin
        pred_c = btb_hit_c;
        if (btb_hit_c) next_pc_c = btb_tgt_c;
      end
      default: ;
    endcase
  end

  // Fetch PC and registered outputs: redirect > accept > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      bus.inst_en   <= 1'b0;
      bus.inst_addr <= '0;
      bus.iq_en     <= 1'b0;
      bus.iq_inst   <= '0;
      bus.iq_pc     <= '0;
      bus.iq_bp     <= 1'b0;
      bus.iq_idx    <= '0;
    end else if (bus.rdy) begin
      bus.inst_en <= 1'b1;
      if (redirect_c) begin
        pc            <= bus.commit_pc;
        bus.inst_addr <= bus.commit_pc;
        bus.iq_en     <= 1'b0;
      end else if (accept_c) begin
        pc            <= next_pc_c;
        bus.inst_addr <= next_pc_c;
        bus.iq_en     <= 1'b1;
        bus.iq_inst   <= bus.inst;
        bus.iq_pc     <= pc;
        bus.iq_bp     <= pred_c;
        bus.iq_idx    <= bht_idx_c;
      end else begin
        bus.inst_addr <= pc;
        bus.iq_en     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_bpu.sv
// Directed bench for fetch_bpu: bimodal instance plus a HIST_W=2 gshare instance.
module tb_fetch_bpu;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_P20  = 32'h0200_0063;
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
  localparam logic [31:0] JAL_P100 = 32'h1000_006F;
  localparam logic [31:0] JAL_M100 = 32'hF01F_F06F;
  localparam logic [31:0] JALR     = 32'h0000_8067;

  typedef struct packed {
    logic        rdy;
    logic        valid;
    logic        full;
    logic [31:0] inst;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic        exp_bp;
    logic [31:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t t1 [$];
  vec_t t2 [$];

  always #5 clk = ~clk;

  fetch_bpu_if #(.ADDR_W(32), .BHT_IDX_W(8)) bus0 ();
  fetch_bpu_if #(.ADDR_W(32), .BHT_IDX_W(8)) bus1 ();

  fetch_bpu #(.HIST_W(0)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
  fetch_bpu #(.HIST_W(2)) u_gsh (.clk(clk), .rst(rst), .bus(bus1));

  function automatic vec_t mk(input logic r, input logic v, input logic f,
                              input logic [31:0] i, input logic e,
                              input logic [31:0] p, input logic b,
                              input logic [31:0] a);
    vec_t x;
    x.rdy = r; x.valid = v; x.full = f; x.inst = i;
    x.exp_en = e; x.exp_pc = p; x.exp_bp = b; x.exp_addr = a;
    return x;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input logic r, input logic v, input logic f, input logic [31:0] i);
    bus0.rdy = r; bus0.inst_valid = v; bus0.iq_full = f; bus0.inst = i;
  endtask

  task automatic commit0(input logic en, input logic jalr, input logic judge, input logic bp,
                         input logic [7:0] idx, input logic [31:0] pc, input logic [31:0] opc);
    bus0.commit_en = en; bus0.commit_isjalr = jalr; bus0.commit_judge = judge;
    bus0.commit_bp = bp; bus0.commit_idx = idx; bus0.commit_pc = pc; bus0.commit_oripc = opc;
  endtask

  task automatic commit1(input logic en, input logic judge, input logic bp, input logic [31:0] pc);
    bus1.commit_en = en; bus1.commit_isjalr = 1'b0; bus1.commit_judge = judge;
    bus1.commit_bp = bp; bus1.commit_idx = 8'h00; bus1.commit_pc = pc; bus1.commit_oripc = '0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    fetch0(v.rdy, v.valid, v.full, v.inst);
    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    tick();
    chk1({tag, "/iq_en"}, bus0.iq_en, v.exp_en);
    chk32({tag, "/inst_addr"}, bus0.inst_addr, v.exp_addr);
    if (v.exp_en) begin
      chk32({tag, "/iq_pc"}, bus0.iq_pc, v.exp_pc);
      chk1({tag, "/iq_bp"}, bus0.iq_bp, v.exp_bp);
    end
  endtask

  initial begin
    // Stimulus tables: {rdy, valid, full, inst, exp iq_en, exp iq_pc, exp iq_bp, exp inst_addr}
    t1.push_back(mk(1'b1, 1'b1, 1'b0, NOP,     1'b1, 32'h00, 1'b0, 32'h04));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, NOP,     1'b1, 32'h04, 1'b0, 32'h08));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, NOP,     1'b1, 32'h08, 1'b0, 32'h0C));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, NOP,     1'b1, 32'h0C, 1'b0, 32'h10));
    t1.push_back(mk(1'b1, 1'b1, 1'b0, BEQ_P20, 1'b1, 32'h10, 1'b1, 32'h30));
    t1.push_back(mk(1'b0, 1'b1, 1'b0, NOP,     1'b1, 32'h10, 1'b1, 32'h30));
    t1.push_back(mk(1'b1, 1'b0, 1'b0, NOP,     1'b0, 32'h00, 1'b0, 32'h30));

    t2.push_back(mk(1'b1, 1'b1, 1'b0, JAL_P100, 1'b1, 32'h01C, 1'b0, 32'h11C));
    t2.push_back(mk(1'b1, 1'b1, 1'b0, JAL_M100, 1'b1, 32'h11C, 1'b0, 32'h01C));
    t2.push_back(mk(1'b1, 1'b1, 1'b0, BEQ_M8,   1'b1, 32'h01C, 1'b1, 32'h014));
    t2.push_back(mk(1'b1, 1'b1, 1'b0, JALR,     1'b1, 32'h014, 1'b0, 32'h018));

    fetch0(1'b1, 1'b0, 1'b0, NOP);
    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    bus1.rdy = 1'b1; bus1.inst_valid = 1'b0; bus1.iq_full = 1'b0; bus1.inst = NOP;
    commit1(1'b0, 1'b0, 1'b0, 32'h0);

    rst = 1'b1;
    tick();
    tick();
    chk1("rst/iq_en", bus0.iq_en, 1'b0);
    chk32("rst/inst_addr", bus0.inst_addr, 32'h0);
    chk32("rst/iq_pc", bus0.iq_pc, 32'h0);
    chk1("rst/iq_bp", bus0.iq_bp, 1'b0);
    chk32("rst/iq_idx", 32'(bus0.iq_idx), 32'h0);
    chk32("rst/gsh_addr", bus1.inst_addr, 32'h0);
    rst = 1'b0;

    // Sequential NOPs, fresh-BHT taken branch, rdy freeze, cache miss hold
    for (int i = 0; i < t1.size(); i++) begin
      apply(t1[i], $sformatf("t1[%0d]", i));
      if (i == 0) chk1("inst_en", bus0.inst_en, 1'b1);
    end

    // Mispredict redirect drops the arriving inst and trains idx 4 down
    fetch0(1'b1, 1'b1, 1'b0, NOP);
    commit0(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 32'h10, 32'h0);
    tick();
    chk1("redir/iq_en", bus0.iq_en, 1'b0);
    chk32("redir/inst_addr", bus0.inst_addr, 32'h10);

    // Two more not-taken commits: counter reaches 0 and stays there
    fetch0(1'b1, 1'b0, 1'b0, NOP);
    commit0(1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 32'h0, 32'h0);
    tick();
    chk32("train1/inst_addr", bus0.inst_addr, 32'h10);
    tick();
    chk32("train2/inst_addr", bus0.inst_addr, 32'h10);

    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    fetch0(1'b1, 1'b1, 1'b0, BEQ_P20);
    tick();
    chk1("refetch/iq_en", bus0.iq_en, 1'b1);
    chk32("refetch/iq_pc", bus0.iq_pc, 32'h10);
    chk1("refetch/iq_bp", bus0.iq_bp, 1'b0);
    chk32("refetch/iq_idx", 32'(bus0.iq_idx), 32'h04);
    chk32("refetch/inst_addr", bus0.inst_addr, 32'h14);

    fetch0(1'b1, 1'b1, 1'b0, NOP);
    tick();
    chk32("nop14/iq_pc", bus0.iq_pc, 32'h14);
    chk32("nop14/inst_addr", bus0.inst_addr, 32'h18);

    // Redirect back to 0x14 with a valid inst in flight
    commit0(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 32'h14, 32'h0);
    tick();
    chk1("drop/iq_en", bus0.iq_en, 1'b0);
    chk32("drop/inst_addr", bus0.inst_addr, 32'h14);

    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    tick();
    chk1("after_drop/iq_en", bus0.iq_en, 1'b1);
    chk32("after_drop/iq_pc", bus0.iq_pc, 32'h14);
    chk32("after_drop/inst_addr", bus0.inst_addr, 32'h18);

    // InstQueue full for three cycles holds the fetch PC
    fetch0(1'b1, 1'b1, 1'b1, NOP);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("full%0d/iq_en", i), bus0.iq_en, 1'b0);
      chk32($sformatf("full%0d/inst_addr", i), bus0.inst_addr, 32'h18);
    end
    fetch0(1'b1, 1'b1, 1'b0, NOP);
    tick();
    chk1("resume/iq_en", bus0.iq_en, 1'b1);
    chk32("resume/iq_pc", bus0.iq_pc, 32'h18);
    chk32("resume/inst_addr", bus0.inst_addr, 32'h1C);

    // JAL forward/backward, backward taken branch, JALR without BTB entry
    for (int i = 0; i < t2.size(); i++) apply(t2[i], $sformatf("t2[%0d]", i));

    // JALR commit installs 0x40 -> 0x200, then branch redirect to 0x40
    fetch0(1'b1, 1'b0, 1'b0, NOP);
    commit0(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h200, 32'h40);
    tick();
    chk32("jalr_commit/inst_addr", bus0.inst_addr, 32'h200);
    commit0(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 32'h40, 32'h0);
    tick();
    chk32("to40/inst_addr", bus0.inst_addr, 32'h40);

    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    fetch0(1'b1, 1'b1, 1'b0, JALR);
    tick();
    chk1("jalr40/iq_en", bus0.iq_en, 1'b1);
    chk32("jalr40/iq_pc", bus0.iq_pc, 32'h40);
`ifdef FETCH_BTB_EN
    chk1("jalr40/iq_bp", bus0.iq_bp, 1'b1);
    chk32("jalr40/inst_addr", bus0.inst_addr, 32'h200);
`else
    chk1("jalr40/iq_bp", bus0.iq_bp, 1'b0);
    chk32("jalr40/inst_addr", bus0.inst_addr, 32'h44);
`endif

    // Correctly predicted JALR commits only skip the redirect when a BTB exists
    fetch0(1'b1, 1'b1, 1'b0, NOP);
    commit0(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 32'h200, 32'h40);
    tick();
`ifdef FETCH_BTB_EN
    chk1("jalr_ok/iq_en", bus0.iq_en, 1'b1);
    chk32("jalr_ok/iq_pc", bus0.iq_pc, 32'h200);
    chk32("jalr_ok/inst_addr", bus0.inst_addr, 32'h204);
`else
    chk1("jalr_ok/iq_en", bus0.iq_en, 1'b0);
    chk32("jalr_ok/inst_addr", bus0.inst_addr, 32'h200);
`endif
    commit0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    fetch0(1'b1, 1'b0, 1'b0, NOP);

    // Gshare: redirect to 0x10 with taken, then taken again -> ghr = 2'b11
    commit1(1'b1, 1'b1, 1'b0, 32'h10);
    tick();
    chk32("gsh_redir/inst_addr", bus1.inst_addr, 32'h10);
    commit1(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    chk32("gsh_hold/inst_addr", bus1.inst_addr, 32'h10);
    chk1("gsh_hold/iq_en", bus1.iq_en, 1'b0);
    commit1(1'b0, 1'b0, 1'b0, 32'h0);
    bus1.inst_valid = 1'b1;
    tick();
    chk1("gsh_fetch/iq_en", bus1.iq_en, 1'b1);
    chk32("gsh_fetch/iq_pc", bus1.iq_pc, 32'h10);
    chk32("gsh_fetch/iq_idx", 32'(bus1.iq_idx), 32'hC4);
    bus1.inst_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
